mem_responder: RTL and testbench

//  Memory-side responder for the processor's address/data bus. Accepts one

---
 rtl/mem_responder_if.sv | 38 +++
 rtl/mem_responder.sv | 231 +++++++++++++++++++++++
 tb/tb_mem_responder.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// -----------------------------------------------------------------------------
// mem_responder_if
// Request/response bus between the datapath (master) and the memory-side
// responder (slave).
//
// Signals
//   req    master->slave  request strobe, sampled on the rising clock edge
//   we     master->slave  1 = write, 0 = read; sampled together with req
//   addr   master->slave  word address; sampled together with req
//   wdata  master->slave  write data; sampled together with req
//   rdata  slave->master  registered read data (holds until the next read)
//   ready  slave->master  one-cycle pulse: access completed
//   busy   slave->master  transaction in progress; req ignored while high
//   err    slave->master  one-cycle pulse: dropped req or bad address
// -----------------------------------------------------------------------------
interface mem_responder_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 7
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic              busy;
    logic              err;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ready, busy, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ready, busy, err
    );
endinterface

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Memory-side responder for the processor address/data bus. One request is
// captured per transaction, an optional number of wait states elapses, then
// the access is performed on a DEPTH-word RAM and a one-cycle ready pulse is
// returned together with registered read data.
//
// Ports
//   clock    in   rising-edge system clock
//   reset_n  in   asynchronous active-low reset (RAM contents are kept)
//   bus      slave modport of mem_responder_if (req/we/addr/wdata in,
//            rdata/ready/busy/err out); all outputs are registered
//
// Parameters
//   DATA_W       data word width
//   ADDR_W       address width
//   DEPTH        number of RAM words, 1..2**ADDR_W
//   WAIT_STATES  extra cycles between request capture and response, 0..15
//
// Configuration macro
//   MEM_ADDR_CHECK_EN  defined:   addresses >= DEPTH complete in time, the
//                                 write is suppressed, a read returns 0 and
//                                 err pulses together with ready.
//                      undefined: addresses are reduced modulo DEPTH.
// -----------------------------------------------------------------------------
module mem_responder #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 7,
    parameter int DEPTH       = 128,
    parameter int WAIT_STATES = 0
) (
    input  logic            clock,
    input  logic            reset_n,
    mem_responder_if.slave  bus
);

    // Index width of the RAM array; equals ADDR_W when DEPTH = 2**ADDR_W.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // DEPTH expressed at address width + 1 so it can be compared/divided
    // against a zero-extended address without width mismatches.
    localparam logic [ADDR_W:0] DEPTH_V = DEPTH[ADDR_W:0];

    // Wait-state preload; only meaningful when WAIT_STATES > 0.
    localparam logic [3:0] WS_V = WAIT_STATES[3:0];

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Address helpers
    // -------------------------------------------------------------------------
`ifdef MEM_ADDR_CHECK_EN
    // True when the address falls inside the implemented RAM.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_V);
    endfunction
`else
    localparam bit FULL_DEPTH = (DEPTH == (1 << ADDR_W));

    // Reduce an address modulo DEPTH; a full-size RAM needs no reduction.
    function automatic logic [IDX_W-1:0] wrap_idx(input logic [ADDR_W-1:0] a);
        logic [ADDR_W:0] r;
        if (FULL_DEPTH) begin
            r = {1'b0, a};
        end else begin
            r = {1'b0, a} % DEPTH_V;
        end
        return r[IDX_W-1:0];
    endfunction
`endif

    // -------------------------------------------------------------------------
    // State and storage
    // -------------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [3:0]        cnt_q,   cnt_d;
    logic              we_q,    we_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              busy_q,  busy_d;
    logic              err_q,   err_d;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Access strobe and operands for the edge on which the RAM is touched.
    // With zero wait states the access uses the live request fields,
    // otherwise it uses the fields latched at capture.
    logic              acc_go_s;
    logic              acc_we_s;
    logic [ADDR_W-1:0] acc_addr_s;
    logic [DATA_W-1:0] acc_wdata_s;
    logic              mem_we_s;
    logic [IDX_W-1:0]  mem_idx_s;

    // Next-state, access and output computation for the transaction FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        ready_d     = 1'b0;
        busy_d      = busy_q;
        err_d       = 1'b0;
        acc_go_s    = 1'b0;
        acc_we_s    = we_q;
        acc_addr_s  = addr_q;
        acc_wdata_s = wdata_q;
        mem_we_s    = 1'b0;
        mem_idx_s   = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    we_d    = bus.we;
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    busy_d  = 1'b1;
                    if (WAIT_STATES == 0) begin
                        acc_go_s    = 1'b1;
                        acc_we_s    = bus.we;
                        acc_addr_s  = bus.addr;
                        acc_wdata_s = bus.wdata;
                        state_d     = ST_RESP;
                    end else begin
                        cnt_d   = WS_V - 4'd1;
                        state_d = ST_WAIT;
                    end
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_WAIT: begin
                // A request arriving mid-transaction is dropped and flagged.
                err_d = bus.req;
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    acc_go_s = 1'b1;
                    state_d  = ST_RESP;
                end
            end
            ST_RESP: begin
                err_d   = bus.req;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        if (acc_go_s) begin
            ready_d = 1'b1;
`ifdef MEM_ADDR_CHECK_EN
            if (addr_in_range(acc_addr_s)) begin
                mem_idx_s = acc_addr_s[IDX_W-1:0];
                if (acc_we_s) begin
                    mem_we_s = 1'b1;
                end else begin
                    rdata_d = mem_q[mem_idx_s];
                end
            end else begin
                // Out of range: timing unchanged, write dropped, read gives 0.
                err_d = 1'b1;
                if (acc_we_s) begin
                    mem_we_s = 1'b0;
                end else begin
                    rdata_d = '0;
                end
            end
`else
            mem_idx_s = wrap_idx(acc_addr_s);
            if (acc_we_s) begin
                mem_we_s = 1'b1;
            end else begin
                rdata_d = mem_q[mem_idx_s];
            end
`endif
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // FSM state, latched request and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // RAM write port. Not reset so contents survive reset_n; writes are
    // blocked while reset is asserted so an abandoned write never lands.
    always_ff @(posedge clock) begin
        if (mem_we_s && reset_n) begin
            mem_q[mem_idx_s] <= acc_wdata_s;
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
    assign bus.err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
// Directed bench for mem_responder. Four instances share one clock/reset:
//   0: WAIT_STATES=0, DEPTH=128    1: WAIT_STATES=3, DEPTH=128
//   2: WAIT_STATES=2, DEPTH=128    3: WAIT_STATES=0, DEPTH=100
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_responder;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic        req_a   [4];
    logic        we_a    [4];
    logic [6:0]  addr_a  [4];
    logic [15:0] wdata_a [4];
    logic [15:0] rdata_a [4];
    logic        ready_a [4];
    logic        busy_a  [4];
    logic        err_a   [4];

    int n_chk = 0;
    int n_bad = 0;

`ifdef MEM_ADDR_CHECK_EN
    localparam bit ADDR_CHK = 1'b1;
`else
    localparam bit ADDR_CHK = 1'b0;
`endif

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        mem_responder_if #(.DATA_W(16), .ADDR_W(7)) bus ();
        assign bus.req     = req_a[g];
        assign bus.we      = we_a[g];
        assign bus.addr    = addr_a[g];
        assign bus.wdata   = wdata_a[g];
        assign rdata_a[g]  = bus.rdata;
        assign ready_a[g]  = bus.ready;
        assign busy_a[g]   = bus.busy;
        assign err_a[g]    = bus.err;

        mem_responder #(
            .DATA_W      (16),
            .ADDR_W      (7),
            .DEPTH       ((g == 3) ? 100 : 128),
            .WAIT_STATES ((g == 1) ? 3 : ((g == 2) ? 2 : 0))
        ) u_dut (
            .clock   (clk),
            .reset_n (rst_n),
            .bus     (bus)
        );
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One-cycle request, then wait (bounded) for ready; lat = cycles after
    // the capture edge at which ready is seen, -1 on timeout.
    task automatic issue(input int idx, input logic w, input logic [6:0] a,
                         input logic [15:0] d, output int lat,
                         output logic [15:0] rd, output logic er);
        req_a[idx]   = 1'b1;
        we_a[idx]    = w;
        addr_a[idx]  = a;
        wdata_a[idx] = d;
        @(negedge clk);
        req_a[idx] = 1'b0;
        lat = 1;
        while (ready_a[idx] !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (ready_a[idx] !== 1'b1) lat = -1;
        rd = rdata_a[idx];
        er = err_a[idx];
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [15:0] rd;
        logic        er;
        logic [7:0]  bv, rv, ev;

        for (int i = 0; i < 4; i++) begin
            req_a[i] = 1'b0; we_a[i] = 1'b0; addr_a[i] = 7'd0; wdata_a[i] = 16'd0;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state of every instance.
        for (int i = 0; i < 4; i++)
            check_eq($sformatf("reset_%0d", i),
                     {13'd0, rdata_a[i], ready_a[i], busy_a[i], err_a[i]}, 32'd0);

        // T1: zero wait states, write then read addr 5.
        issue(0, 1'b1, 7'd5, 16'h0123, lat, rd, er);
        check_eq("t1_wr_lat", 32'(lat), 32'd1);
        check_eq("t1_wr_rdata_hold", {16'd0, rd}, 32'd0);
        check_eq("t1_wr_err", {31'd0, er}, 32'd0);
        issue(0, 1'b0, 7'd5, 16'h0000, lat, rd, er);
        check_eq("t1_rd_lat", 32'(lat), 32'd1);
        check_eq("t1_rd_data", {16'd0, rd}, 32'h0123);

        // T2: three wait states; busy/ready profile of a read.
        issue(1, 1'b1, 7'd5, 16'h0123, lat, rd, er);
        check_eq("t2_wr_lat", 32'(lat), 32'd4);
        bv = 8'd0; rv = 8'd0; rd = 16'd0;
        req_a[1] = 1'b1; we_a[1] = 1'b0; addr_a[1] = 7'd5;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            req_a[1] = 1'b0;
            bv[c] = busy_a[1];
            rv[c] = ready_a[1];
            if (ready_a[1] === 1'b1) rd = rdata_a[1];
        end
        check_eq("t2_busy_profile", {24'd0, bv}, 32'h0F);
        check_eq("t2_ready_profile", {24'd0, rv}, 32'h08);
        check_eq("t2_rd_data", {16'd0, rd}, 32'h0123);

        // T3: req held high through a two-wait-state read.
        issue(2, 1'b1, 7'd7, 16'h5A5A, lat, rd, er);
        check_eq("t3_wr_lat", 32'(lat), 32'd3);
        bv = 8'd0; rv = 8'd0; ev = 8'd0; rd = 16'd0;
        req_a[2] = 1'b1; we_a[2] = 1'b0; addr_a[2] = 7'd7;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            bv[c] = busy_a[2];
            rv[c] = ready_a[2];
            ev[c] = err_a[2];
            if (c == 2) rd = rdata_a[2];
            if (c == 4) req_a[2] = 1'b0;
        end
        check_eq("t3_ready_profile", {24'd0, rv}, 32'h44);
        check_eq("t3_err_profile", {24'd0, ev}, 32'h0E);
        check_eq("t3_busy_profile", {24'd0, bv}, 32'h77);
        check_eq("t3_rd_data", {16'd0, rd}, 32'h5A5A);

        // T4: reset during WAIT abandons a pending write.
        issue(1, 1'b1, 7'd9, 16'h1111, lat, rd, er);
        check_eq("t4_pre_lat", 32'(lat), 32'd4);
        req_a[1] = 1'b1; we_a[1] = 1'b1; addr_a[1] = 7'd9; wdata_a[1] = 16'hBEEF;
        @(negedge clk);
        req_a[1] = 1'b0;
        @(negedge clk);
        check_eq("t4_busy_mid", {31'd0, busy_a[1]}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("t4_outputs_reset",
                 {13'd0, rdata_a[1], ready_a[1], busy_a[1], err_a[1]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(1, 1'b0, 7'd9, 16'h0000, lat, rd, er);
        check_eq("t4_rd_lat", 32'(lat), 32'd4);
        check_eq("t4_rd_data", {16'd0, rd}, 32'h1111);

        // T5: DEPTH=100, out-of-range address 120 (aliases 20 when wrapping).
        issue(3, 1'b1, 7'd20, 16'h0F0F, lat, rd, er);
        check_eq("t5_wr20_err", {31'd0, er}, 32'd0);
        issue(3, 1'b1, 7'd120, 16'h00AA, lat, rd, er);
        check_eq("t5_wr120_lat", 32'(lat), 32'd1);
        check_eq("t5_wr120_err", {31'd0, er}, {31'd0, ADDR_CHK});
        issue(3, 1'b0, 7'd20, 16'h0000, lat, rd, er);
        check_eq("t5_rd20_data", {16'd0, rd}, ADDR_CHK ? 32'h0F0F : 32'h00AA);
        issue(3, 1'b0, 7'd120, 16'h0000, lat, rd, er);
        check_eq("t5_rd120_lat", 32'(lat), 32'd1);
        check_eq("t5_rd120_data", {16'd0, rd}, ADDR_CHK ? 32'h0000 : 32'h00AA);
        check_eq("t5_rd120_err", {31'd0, er}, {31'd0, ADDR_CHK});

        // T6: boundary addresses with all-ones / all-zeros data.
        issue(0, 1'b1, 7'd0,   16'hFFFF, lat, rd, er);
        issue(0, 1'b1, 7'd127, 16'h0000, lat, rd, er);
        issue(0, 1'b0, 7'd0,   16'h0000, lat, rd, er);
        check_eq("t6_rd0_data", {16'd0, rd}, 32'hFFFF);
        issue(0, 1'b0, 7'd127, 16'h0000, lat, rd, er);
        check_eq("t6_rd127_data", {16'd0, rd}, 32'h0000);
        issue(0, 1'b1, 7'd0,   16'h1234, lat, rd, er);
        check_eq("t6_wr_rdata_hold", {16'd0, rd}, 32'h0000);
        issue(0, 1'b0, 7'd0,   16'h0000, lat, rd, er);
        check_eq("t6_rd0_new", {16'd0, rd}, 32'h1234);
        issue(3, 1'b1, 7'd99,  16'hFFFF, lat, rd, er);
        check_eq("t6_wr99_err", {31'd0, er}, 32'd0);
        issue(3, 1'b0, 7'd99,  16'h0000, lat, rd, er);
        check_eq("t6_rd99_data", {16'd0, rd}, 32'hFFFF);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
